// File: rtl/rf_exec_ctrl.sv
// Execution/write-back sequencer feeding an 8x8 register file: reads two operands,
// runs a single-cycle ALU op or an 8-step shift-add multiply, then writes back once.
module rf_exec_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic [2:0]    opcode,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [DW-1:0] imm,
  output logic [AW-1:0] RX,
  output logic [AW-1:0] RY,
  input  logic [DW-1:0] busX,
  input  logic [DW-1:0] busY,
  output logic          WEN,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic          done,
  output logic          ovf
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_LDI, OP_MUL
  } op_t;

  state_t          state, next_state;
  op_t             op_q;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   imm_q;
  logic [2*DW-1:0] opa_q;      // X operand; doubles as the left-shifting multiplicand
  logic [DW-1:0]   opb_q;      // Y operand; doubles as the right-shifting multiplier
  logic [2*DW-1:0] acc_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;

  logic            accept;
  logic            last_iter;
  logic [DW-1:0]   a, b;
  logic [2*DW-1:0] acc_next;
  logic [DW-1:0]   alu_res;
  logic            alu_ovf;

  assign inst_ready = (state == IDLE);
  assign accept     = inst_valid && inst_ready;
  assign last_iter  = (op_q != OP_MUL) || (cnt_q == CW'(DW - 1));

  assign WEN  = (state == WB);
  assign done = (state == WB);
  assign ovf  = (state == WB) && ovf_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = READ;
      READ:    next_state = EXEC;
      EXEC:    if (last_iter) next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign a        = opa_q[DW-1:0];
  assign b        = opb_q;
  assign acc_next = acc_q + (opb_q[0] ? opa_q : '0);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res = a + b;
        alu_ovf = (a[DW-1] == b[DW-1]) && (alu_res[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        alu_res = a - b;
        alu_ovf = (a[DW-1] != b[DW-1]) && (alu_res[DW-1] != a[DW-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LDI:  alu_res = imm_q;
      OP_MUL: begin
        alu_res = acc_next[DW-1:0];
        alu_ovf = |acc_next[2*DW-1:DW];
      end
      default: alu_res = '0;
    endcase
  end

  // NOTE: all datapath flops are reset so an aborted instruction leaves no trace
  // and the write-back bus starts from a known value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q  <= OP_ADD;
      rd_q  <= '0;
      imm_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      RX    <= '0;
      RY    <= '0;
      RW    <= '0;
      busW  <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q  <= op_t'(opcode);
          rd_q  <= rd;
          imm_q <= imm;
          RX    <= rs;
          RY    <= rt;
        end
        READ: begin
          opa_q <= {{DW{1'b0}}, busX};
          opb_q <= busY;
          acc_q <= '0;
          cnt_q <= '0;
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            acc_q <= acc_next;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
            cnt_q <= cnt_q + 1'b1;
          end
          if (last_iter) begin
            RW    <= rd_q;
            busW  <= alu_res;
            ovf_q <= alu_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Bench for rf_exec_ctrl: a register file plus an instruction-level reference model,
// a per-cycle compare process and directed instruction sequences with literal results.
module tb_rf_exec_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       inst_valid = 1'b0;
  logic [2:0] opcode = '0;
  logic [2:0] rd = '0, rs = '0, rt = '0;
  logic [7:0] imm = '0;
  logic       inst_ready;
  logic [2:0] RX, RY, RW;
  logic [7:0] busX, busY, busW;
  logic       WEN, done, ovf;

  rf_exec_ctrl #(.DW(8), .AW(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .RX(RX), .RY(RY), .busX(busX), .busY(busY),
    .WEN(WEN), .RW(RW), .busW(busW), .done(done), .ovf(ovf)
  );

  always #5 Clk = ~Clk;

  // Register file the DUT talks to; r0 reads as zero and is never stored.
  logic [7:0] rf [8] = '{default: 8'h00};
  assign busX = (RX == 3'd0) ? 8'h00 : rf[RX];
  assign busY = (RY == 3'd0) ? 8'h00 : rf[RY];
  always @(posedge Clk) if (WEN && RW != 3'd0) rf[RW] <= busW;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: one instruction in flight, write-back 3 or 10 cycles after accept.
  int         cyc = 0;
  int         wb_cyc = -1;
  int         ref_regs [8];
  logic [2:0] p_rd = '0, last_rw = '0;
  logic [7:0] p_res = '0, last_bw = '0;
  logic       p_ovf = 1'b0;

  initial begin
    int x, y, sx, sy, r;
    logic o;
    for (int i = 0; i < 8; i++) ref_regs[i] = 0;
    forever begin
      @(posedge Clk or negedge Rst_n);
      if (!Rst_n) begin
        wb_cyc  = -1;
        last_rw = '0;
        last_bw = '0;
      end else begin
        if (cyc == wb_cyc) begin
          last_rw = p_rd;
          last_bw = p_res;
          if (p_rd != 3'd0) ref_regs[p_rd] = int'(p_res);
        end else if (inst_valid && cyc > wb_cyc) begin
          x  = ref_regs[rs];
          y  = ref_regs[rt];
          sx = (x > 127) ? x - 256 : x;
          sy = (y > 127) ? y - 256 : y;
          o  = 1'b0;
          case (opcode)
            3'd0: begin r = sx + sy; o = (r > 127) || (r < -128); end
            3'd1: begin r = sx - sy; o = (r > 127) || (r < -128); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = (sx < sy) ? 1 : 0;
            3'd6: r = int'(imm);
            default: begin r = x * y; o = (r > 255); end
          endcase
          p_rd   = rd;
          p_res  = 8'(r);
          p_ovf  = o;
          wb_cyc = cyc + ((opcode == 3'd7) ? 10 : 3);
        end
        cyc++;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    logic ew;
    forever begin
      @(negedge Clk);
      ew = (cyc == wb_cyc);
      check("ready", inst_ready, (cyc > wb_cyc));
      check("wen", WEN, ew);
      check("done", done, ew);
      check("ovf", ovf, ew ? p_ovf : 1'b0);
      check("rw", RW, ew ? p_rd : last_rw);
      check("busw", busW, ew ? p_res : last_bw);
    end
  end

  // Issue one instruction, wait for its write-back and check it against literal values.
  task automatic run_inst(input string name, input logic [2:0] op, input logic [2:0] d,
                          input logic [2:0] s, input logic [2:0] t, input logic [7:0] im,
                          input logic [7:0] exp_bw, input logic exp_ov, input int exp_lat,
                          output int waits);
    logic r, accepted, seen;
    int   lat;
    @(posedge Clk);
    #1;
    opcode = op; rd = d; rs = s; rt = t; imm = im; inst_valid = 1'b1;
    waits = 0;
    accepted = 1'b0;
    while (!accepted && waits < 20) begin
      @(negedge Clk);
      r = inst_ready;
      @(posedge Clk);
      if (r) accepted = 1'b1;
      else   waits++;
    end
    #1 inst_valid = 1'b0;
    check({name, " accepted"}, accepted, 1'b1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge Clk);
      lat++;
      if (WEN) seen = 1'b1;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " rw"}, RW, d);
    check({name, " busw"}, busW, exp_bw);
    check({name, " ovf"}, ovf, exp_ov);
    check({name, " done"}, done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n_acc, n_done;
    @(negedge Clk);
    check("rst ready", inst_ready, 1'b1);
    check("rst wen", WEN, 1'b0);
    check("rst rx", RX, 3'd0);
    check("rst ry", RY, 3'd0);
    check("rst rw", RW, 3'd0);
    check("rst busw", busW, 8'h00);
    @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Basic sequence and back-to-back accept after write-back.
    run_inst("ldi r1", 3'd6, 3'd1, 3'd0, 3'd0, 8'h05, 8'h05, 1'b0, 3, w);
    run_inst("ldi r2", 3'd6, 3'd2, 3'd0, 3'd0, 8'h03, 8'h03, 1'b0, 3, w);
    run_inst("add r3", 3'd0, 3'd3, 3'd1, 3'd2, 8'h00, 8'h08, 1'b0, 3, w);
    run_inst("ldi r1 7f", 3'd6, 3'd1, 3'd0, 3'd0, 8'h7F, 8'h7F, 1'b0, 3, w);
    check("accept after wb", w, 0);

    // Signed overflow and set-less-than.
    run_inst("ldi r2 01", 3'd6, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 1'b0, 3, w);
    run_inst("add ovf", 3'd0, 3'd4, 3'd1, 3'd2, 8'h00, 8'h80, 1'b1, 3, w);
    run_inst("sub neg", 3'd1, 3'd5, 3'd2, 3'd1, 8'h00, 8'h82, 1'b0, 3, w);
    run_inst("slt 0", 3'd5, 3'd6, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0, 3, w);
    run_inst("ldi r1 ff", 3'd6, 3'd1, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0, 3, w);
    run_inst("slt 1", 3'd5, 3'd6, 3'd1, 3'd2, 8'h00, 8'h01, 1'b0, 3, w);

    // Multiply latency and high-byte overflow.
    run_inst("ldi r1 13", 3'd6, 3'd1, 3'd0, 3'd0, 8'd13, 8'h0D, 1'b0, 3, w);
    run_inst("ldi r2 11", 3'd6, 3'd2, 3'd0, 3'd0, 8'd11, 8'h0B, 1'b0, 3, w);
    run_inst("mul 143", 3'd7, 3'd6, 3'd1, 3'd2, 8'h00, 8'h8F, 1'b0, 10, w);
    run_inst("ldi r1 20", 3'd6, 3'd1, 3'd0, 3'd0, 8'd20, 8'h14, 1'b0, 3, w);
    run_inst("ldi r2 20", 3'd6, 3'd2, 3'd0, 3'd0, 8'd20, 8'h14, 1'b0, 3, w);
    run_inst("mul 400", 3'd7, 3'd6, 3'd1, 3'd2, 8'h00, 8'h90, 1'b1, 10, w);

    // r0 write pulses but is discarded.
    run_inst("ldi r0", 3'd6, 3'd0, 3'd0, 3'd0, 8'h55, 8'h55, 1'b0, 3, w);
    run_inst("add r0 r0", 3'd0, 3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 3, w);

    // Held valid for 12 cycles: three accepts, three write-backs.
    @(posedge Clk);
    #1;
    opcode = 3'd0; rd = 3'd3; rs = 3'd3; rt = 3'd2; inst_valid = 1'b1;
    n_acc = 0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (inst_ready) n_acc++;
      if (done) n_done++;
      @(posedge Clk);
      #1;
    end
    inst_valid = 1'b0;
    check("hold accepts", n_acc, 3);
    check("hold dones", n_done, 3);
    check("hold r3", rf[3], 8'h44);

    // Reset during the fourth multiply iteration aborts the write.
    @(posedge Clk);
    #1;
    opcode = 3'd7; rd = 3'd4; rs = 3'd1; rt = 3'd2; inst_valid = 1'b1;
    @(negedge Clk);
    check("mul abort accept", inst_ready, 1'b1);
    @(posedge Clk);
    #1 inst_valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    check("abort wen", WEN, 1'b0);
    check("abort done", done, 1'b0);
    check("abort ready", inst_ready, 1'b1);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    check("abort r4 kept", rf[4], 8'h80);
    run_inst("read r4", 3'd0, 3'd7, 3'd4, 3'd0, 8'h00, 8'h80, 1'b0, 3, w);

    // Logic ops and further overflow corners.
    run_inst("ldi r1 a5", 3'd6, 3'd1, 3'd0, 3'd0, 8'hA5, 8'hA5, 1'b0, 3, w);
    run_inst("ldi r2 3c", 3'd6, 3'd2, 3'd0, 3'd0, 8'h3C, 8'h3C, 1'b0, 3, w);
    run_inst("and", 3'd2, 3'd5, 3'd1, 3'd2, 8'h00, 8'h24, 1'b0, 3, w);
    run_inst("or", 3'd3, 3'd5, 3'd1, 3'd2, 8'h00, 8'hBD, 1'b0, 3, w);
    run_inst("xor", 3'd4, 3'd5, 3'd1, 3'd2, 8'h00, 8'h99, 1'b0, 3, w);
    run_inst("ldi r1 80", 3'd6, 3'd1, 3'd0, 3'd0, 8'h80, 8'h80, 1'b0, 3, w);
    run_inst("ldi r2 01b", 3'd6, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 1'b0, 3, w);
    run_inst("sub ovf", 3'd1, 3'd5, 3'd1, 3'd2, 8'h00, 8'h7F, 1'b1, 3, w);
    run_inst("ldi r1 ffb", 3'd6, 3'd1, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0, 3, w);
    run_inst("add wrap", 3'd0, 3'd5, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0, 3, w);
    run_inst("mul ff", 3'd7, 3'd6, 3'd1, 3'd1, 8'h00, 8'h01, 1'b1, 10, w);

    repeat (3) @(posedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_exec_ctrl.md
Name: rf_exec_ctrl

Overview:
- Execution/write-back sequencer that sits directly upstream of register_file (8 x 8-bit, REG#0 reads as zero).
- Accepts one instruction at a time over a valid/ready handshake and drives register_file read addresses RX/RY.
- Captures busX/busY, computes the result (single-cycle ALU ops or an 8-iteration shift-add multiply), then drives WEN/RW/busW for exactly one write-back cycle.

Parameters:
- DW, 8, data width; must match register_file bus width.
- AW, 3, register address width (8 registers).

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- inst_valid  input  1  instruction present.
- inst_ready  output  1  block is idle and can accept an instruction.
- opcode  input  3  operation select (see Behaviour).
- rd  input  AW  destination register.
- rs  input  AW  source register X.
- rt  input  AW  source register Y.
- imm  input  DW  immediate for LDI.
- RX  output  AW  register_file read address X.
- RY  output  AW  register_file read address Y.
- busX  input  DW  register_file read data X (combinational from RX).
- busY  input  DW  register_file read data Y (combinational from RY).
- WEN  output  1  register_file write enable.
- RW  output  AW  register_file write address.
- busW  output  DW  register_file write data.
- done  output  1  one-cycle pulse, coincident with the WEN cycle.
- ovf  output  1  overflow flag of the written result; valid while done=1.

Behaviour:
- Opcodes:
  - 000 ADD: rs+rt.
  - 001 SUB: rs-rt.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: 1 if signed rs<rt, else 0.
  - 110 LDI: result = imm; rs/rt ignored.
  - 111 MUL: unsigned, result = low 8 bits of the product.
- ovf rules:
  - ADD/SUB: two's-complement signed overflow.
  - MUL: product[15:8] != 0.
  - All other ops: 0.
- States: IDLE, READ, EXEC, WB.
- inst_ready = 1 only in IDLE, decoded combinationally from state.
- IDLE:
  - On inst_valid && inst_ready at an edge, latch opcode/rd/rs/rt/imm.
  - Drive RX=rs, RY=rt (registered) and go to READ.
- READ (1 cycle): capture busX, busY into operand registers; go to EXEC.
- EXEC:
  - Non-MUL ops: 1 cycle; result and ovf are registered; go to WB.
  - MUL: 8 cycles of shift-add into a 16-bit accumulator, one multiplier bit per cycle, LSB first; go to WB after the 8th iteration.
- WB (1 cycle):
  - WEN=1, RW=rd, busW=result, done=1. The write lands at the edge ending WB.
  - Next state is IDLE.
- Latency from accept edge to the WB cycle: 3 cycles for non-MUL ops, 10 cycles for MUL.
- Next accept happens no earlier than the edge ending the first IDLE cycle after WB, so a dependent instruction always reads the updated value. There is no forwarding.
- WEN, done and ovf are 0 outside WB. RW and busW hold their last value outside WB.
- rd=0 is written normally (WEN pulses); register_file discards it.
- inst_valid while busy is ignored and not queued. The source holds the instruction until accepted.
- Reset values: WEN=0, done=0, ovf=0, RX=0, RY=0, RW=0, busW=0; state=IDLE, so inst_ready=1.
- Reset asserted mid-instruction: aborts immediately, no write occurs, and the aborted instruction is discarded.

Test Plan:
1. LDI r1,5; LDI r2,3; ADD r3,r1,r2.
   - Third instruction: WB cycle occurs 3 cycles after accept with WEN=1, RW=3, busW=8'h08, done=1, ovf=0.
   - A following LDI is accepted the cycle after WB.
2. r1=8'h7F, r2=8'h01.
   - ADD r4 -> busW=8'h80, ovf=1.
   - SUB r5,r2,r1 -> busW=8'h82, ovf=0.
   - SLT r6,r1,r2 -> 0.
   - With r1=8'hFF: SLT r6,r1,r2 -> 1.
3. r1=13, r2=11; MUL r6,r1,r2.
   - inst_ready low for 10 cycles; WB shows busW=8'h8F, ovf=0.
   - With r1=20, r2=20: MUL -> busW=8'h90, ovf=1.
4. LDI r0,8'h55 (WEN pulses, RW=0), then ADD r7,r0,r0 -> busW=8'h00.
5. Hold inst_valid=1 with a fixed instruction for 12 cycles.
   - Exactly 3 accepts and 3 done pulses for a non-MUL op.
6. Assert Rst_n=0 during MUL EXEC cycle 4.
   - WEN/done stay 0 and inst_ready=1 immediately.
   - Destination register keeps its old value, checked by a later ADD rX,rd,r0.
